keypad_scan_ctrl: RTL and testbench

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

---
 rtl/keypad_scan_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : keypad_scan_ctrl
// 4x4 keypad scanner with press/release debounce, key handshake with overrun
// detection, and a 4-digit refresh scheduler for a seven-segment display.
// Rev    : 1.0
// ============================================================================
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 100000,
  parameter int REFRESH_DIV  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_overrun,
  output logic [3:0] anode,
  output logic [3:0] digit_val
);

  localparam int SD_W = $clog2(SCAN_DIV);
  localparam int DB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam int RF_W = $clog2(REFRESH_DIV + 1);

  localparam logic [SD_W-1:0] c_SCAN_LAST = SD_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] c_DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [RF_W-1:0] c_REF_LAST  = RF_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_row_s1;
  logic [3:0]        r_row_s2;
  logic [1:0]        r_col;
  logic [3:0]        r_col_out;
  logic [1:0]        r_row;
  logic [SD_W-1:0]   r_div;
  logic [DB_W-1:0]   r_cnt;
  logic [3:0]        r_key_code;
  logic              r_key_valid;
  logic              r_key_overrun;
  logic [3:0][3:0]   r_dig;
  logic [RF_W-1:0]   r_ref;
  logic [1:0]        r_sel;
  logic [3:0]        r_anode;

  logic              w_any_low;
  logic [1:0]        w_low_idx;
  logic              w_row_low;
  logic [1:0]        w_col_nxt;
  logic [3:0]        w_col_out_nxt;
  logic              w_publish;
  logic [3:0]        w_code;
  logic [1:0]        w_sel_nxt;

  function automatic logic [3:0] f_key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] v;
    case ({row, col})
      4'h0: v = 4'h1;
      4'h1: v = 4'h2;
      4'h2: v = 4'h3;
      4'h3: v = 4'hA;
      4'h4: v = 4'h4;
      4'h5: v = 4'h5;
      4'h6: v = 4'h6;
      4'h7: v = 4'hB;
      4'h8: v = 4'h7;
      4'h9: v = 4'h8;
      4'hA: v = 4'h9;
      4'hB: v = 4'hC;
      4'hC: v = 4'h0;
      4'hD: v = 4'hF;
      4'hE: v = 4'hE;
      4'hF: v = 4'hD;
      default: v = 4'h0;
    endcase
    return v;
  endfunction

  // Rows float high when released; reset the synchronizer to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= row_in;
      r_row_s2 <= r_row_s1;
    end
  end

  always_comb begin
    w_low_idx = 2'd3;
    if (!r_row_s2[0])      w_low_idx = 2'd0;
    else if (!r_row_s2[1]) w_low_idx = 2'd1;
    else if (!r_row_s2[2]) w_low_idx = 2'd2;
  end

  assign w_any_low     = ~&r_row_s2;
  assign w_row_low     = ~r_row_s2[r_row];
  assign w_col_nxt     = r_col + 2'd1;
  assign w_col_out_nxt = ~(4'b0001 << w_col_nxt);
  assign w_code        = f_key_map(r_row, r_col);
  assign w_publish     = (r_state == DEBOUNCE) && w_row_low && (r_cnt == c_DB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SCAN;
      r_col     <= 2'd0;
      r_col_out <= 4'b1110;
      r_row     <= 2'd0;
      r_div     <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        SCAN: begin
          if (r_div == c_SCAN_LAST) begin
            r_div <= '0;
            if (w_any_low) begin
              r_row   <= w_low_idx;
              r_cnt   <= '0;
              r_state <= DEBOUNCE;
            end else begin
              r_col     <= w_col_nxt;
              r_col_out <= w_col_out_nxt;
            end
          end else begin
            r_div <= r_div + SD_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!w_row_low) begin
            r_col     <= w_col_nxt;
            r_col_out <= w_col_out_nxt;
            r_div     <= '0;
            r_state   <= SCAN;
          end else if (r_cnt == c_DB_LAST) begin
            r_state <= HELD;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
        HELD: begin
          if (!w_row_low) begin
            r_cnt   <= '0;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          if (w_row_low) begin
            r_state <= HELD;
          end else if (r_cnt == c_DB_LAST) begin
            r_col     <= w_col_nxt;
            r_col_out <= w_col_out_nxt;
            r_div     <= '0;
            r_state   <= SCAN;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  // An ack landing with a publish frees the slot, so the new key is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_code    <= 4'h0;
      r_key_valid   <= 1'b0;
      r_key_overrun <= 1'b0;
      r_dig         <= '0;
    end else if (w_publish) begin
      if (!r_key_valid || key_ack) begin
        r_key_code  <= w_code;
        r_key_valid <= 1'b1;
        r_dig       <= {r_dig[2:0], w_code};
      end else begin
        r_key_overrun <= 1'b1;
      end
    end else if (key_ack && r_key_valid) begin
      r_key_valid <= 1'b0;
    end
  end

  assign w_sel_nxt = r_sel + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref   <= '0;
      r_sel   <= 2'd0;
      r_anode <= 4'b1110;
    end else if (r_ref == c_REF_LAST) begin
      r_ref   <= '0;
      r_sel   <= w_sel_nxt;
      r_anode <= ~(4'b0001 << w_sel_nxt);
    end else begin
      r_ref <= r_ref + RF_W'(1);
    end
  end

  assign col_out     = r_col_out;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_overrun = r_key_overrun;
  assign anode       = r_anode;
  assign digit_val   = r_dig[r_sel];

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_keypad_scan_ctrl
// Self-checking bench: keypad model plus a key/display reference model.
// Rev    : 1.0
// ============================================================================
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int REFRESH_DIV  = 4;
  // Column first driven (cycle a) -> sampled at a+SCAN_DIV-1 -> valid seen at a+PUB_LAT.
  localparam int PUB_LAT      = SCAN_DIV + DEBOUNCE_CNT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_overrun;
  logic [3:0] anode;
  logic [3:0] digit_val;

  keypad_scan_ctrl #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ack    (key_ack),
    .key_overrun(key_overrun),
    .anode      (anode),
    .digit_val  (digit_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical keypad: a pressed key shorts its row to the column being driven low.
  logic       key_on  = 1'b0;
  logic [3:0] key_idx = 4'd0;
  always_comb begin
    row_in = 4'hF;
    if (key_on && (col_out[key_idx[1:0]] == 1'b0)) row_in[key_idx[3:2]] = 1'b0;
  end

  int unsigned kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  logic [3:0] m_code;
  bit         m_valid;
  bit         m_ovr;
  logic [3:0] m_hist [$];
  int         rel;
  int         n_pass  = 0;
  int         n_total = 0;

  function automatic void m_reset();
    m_code  = 4'h0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_hist.delete();
  endfunction

  function automatic void m_publish(input logic [3:0] code, input bit ack);
    if (!m_valid || ack) begin
      m_code  = code;
      m_valid = 1'b1;
      m_hist.push_front(code);
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  function automatic logic [3:0] m_digit(input int s);
    return (s < m_hist.size()) ? m_hist[s] : 4'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_code"},    {28'd0, key_code},    {28'd0, m_code});
    chk({tag, "_valid"},   {31'd0, key_valid},   {31'd0, m_valid});
    chk({tag, "_overrun"}, {31'd0, key_overrun}, {31'd0, m_ovr});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_col"},     {28'd0, col_out},     32'h0000000E);
    chk({tag, "_code"},    {28'd0, key_code},    32'h0);
    chk({tag, "_valid"},   {31'd0, key_valid},   32'h0);
    chk({tag, "_overrun"}, {31'd0, key_overrun}, 32'h0);
    chk({tag, "_anode"},   {28'd0, anode},       32'h0000000E);
    chk({tag, "_digit"},   {28'd0, digit_val},   32'h0);
  endtask

  task automatic chk_display(input string tag, input int n);
    int         s;
    logic [3:0] ea;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s = ((cyc - rel) / REFRESH_DIV) % 4;
      ea = 4'hF;
      ea[s[1:0]] = 1'b0;
      chk({tag, "_anode"}, {28'd0, anode},     {28'd0, ea});
      chk({tag, "_digit"}, {28'd0, digit_val}, {28'd0, m_digit(s)});
    end
  endtask

  task automatic wait_col(input logic [3:0] tp, input bit want, input string tag);
    int n;
    n = 0;
    while (((col_out == tp) != want) && (n < 64)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      n_total++;
      $error("FAIL %s_col_timeout observed=%b expected_match=%0d pattern=%b", tag, col_out, want, tp);
    end
  endtask

  // Starts the press just before its column is driven so detection timing is known.
  task automatic press(input logic [3:0] k, input int hold, input bit ack_pub, input string tag);
    logic [3:0] tp;
    bit         v_pre;
    tp = 4'hF;
    tp[k[1:0]] = 1'b0;
    wait_col(tp, 1'b0, tag);
    key_idx = k;
    key_on  = 1'b1;
    wait_col(tp, 1'b1, tag);
    v_pre = m_valid;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (hold >= PUB_LAT) begin
        if (i == PUB_LAT - 1) begin
          chk({tag, "_valid_pre"}, {31'd0, key_valid}, {31'd0, v_pre});
          if (ack_pub) key_ack = 1'b1;
        end
        if (i == PUB_LAT) begin
          key_ack = 1'b0;
          m_publish(4'(kmap[k]), ack_pub);
          chk_outputs({tag, "_pub"});
        end
      end
    end
  endtask

  task automatic release_key(input int idle);
    key_on = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic do_ack(input string tag);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    m_valid = 1'b0;
    chk({tag, "_ack_valid"}, {31'd0, key_valid}, 32'h0);
  endtask

  logic [3:0] r_k;
  bit         r_long;
  bit         r_ap;
  int         r_h;

  initial begin
    m_reset();
    rel = 0;
    repeat (3) @(negedge clk);
    chk_reset("rst_hold");
    rst = 1'b0;
    rel = cyc;
    chk_reset("rst_release");

    // Key 6 held for 20 cycles of its own column.
    press(4'd6, 20, 1'b0, "k6");
    release_key(30);
    chk_outputs("k6_after");
    chk_display("k6_disp", 16);
    do_ack("k6");
    do_ack("idle");

    // A 5-cycle bounce on key 1 must be rejected and scanning moves to column 1.
    press(4'd0, 5, 1'b0, "bounce");
    key_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bounce_col_hold", {28'd0, col_out}, 32'h0000000E);
    @(negedge clk);
    chk("bounce_col_next", {28'd0, col_out}, 32'h0000000D);
    repeat (20) @(negedge clk);
    chk_outputs("bounce_after");

    // Keys 1, 2, 3, A with an ack after each.
    for (int j = 0; j < 4; j++) begin
      press(4'(j), 15, 1'b0, "seq");
      release_key(30);
      do_ack("seq");
    end
    chk_display("seq_disp", 16);

    // Unacknowledged 5 followed by 9.
    press(4'd5, 15, 1'b0, "k5");
    release_key(30);
    press(4'd10, 15, 1'b0, "k9");
    release_key(30);
    chk_outputs("ovr");
    chk_display("ovr_disp", 16);
    do_ack("ovr");
    chk_outputs("ovr_sticky");

    // Reset while key 0 is held, then it is found again from scratch.
    press(4'd12, 25, 1'b0, "k0");
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_reset();
    chk_reset("rst_mid");
    rst = 1'b0;
    rel = cyc;
    for (int n = 1; n <= PUB_LAT; n++) begin
      @(negedge clk);
      if (n == PUB_LAT - 1) chk("k0_again_pre", {31'd0, key_valid}, 32'h0);
      if (n == PUB_LAT) begin
        m_publish(4'h0, 1'b0);
        chk_outputs("k0_again");
      end
    end
    release_key(30);
    chk_outputs("k0_after");

    // Publish of C coincides with the ack of the pending key 0.
    press(4'd11, 15, 1'b1, "kc_ack");
    release_key(30);
    chk_outputs("kc_ack_after");
    chk_display("kc_disp", 16);

    for (int it = 0; it < 10; it++) begin
      r_k    = 4'($urandom_range(0, 15));
      r_long = ($urandom_range(0, 3) != 0);
      r_h    = r_long ? int'($urandom_range(12, 40)) : int'($urandom_range(3, 7));
      r_ap   = r_long && ($urandom_range(0, 3) == 0);
      press(r_k, r_h, r_ap, "rnd");
      release_key(30);
      chk_outputs("rnd_after");
      if ($urandom_range(0, 1) != 0) do_ack("rnd");
    end
    chk_display("rnd_disp", 16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
`default_nettype wire
